mem_io_access_ctrl: RTL and testbench

//  Sequences every data-side access to data memory and memory-mapped IO. The two requesters are the CPU load/store stage and the UART program loader.
//  - Decodes the address into the memory or IO region.
//  - Arbitrates the requesters; the loader has fixed priority.
//  - Runs a multi-cycle access: it waits out the memory read latency, then returns the data with an ack pulse.
//  - The CPU stalls while its req is high and ack is low.

---
 rtl/mem_io_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_io_access_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_access_ctrl.sv
// Data-side access sequencer: arbitrates the UART loader (fixed priority) and the CPU
// load/store stage onto data memory or memory-mapped IO, one access at a time.
`timescale 1ns/1ps
module mem_io_access_ctrl #(
  parameter int unsigned MEM_RD_LAT = 1,
  parameter logic [31:0] IO_BASE    = 32'hFFFFFC00,
  parameter int unsigned IO_BITS    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        ldr_req,
  input  logic [31:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  output logic        ldr_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic [15:0] io_rdata,
  output logic [15:0] io_wdata,
  output logic        led_ctrl,
  output logic        switch_ctrl,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_LDR  = 1'b1;
  localparam logic [3:0] LAST_CNT = 4'(MEM_RD_LAT - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic        is_io_q, is_io_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  cnt_q, cnt_d;

  function automatic logic addr_is_io(input logic [31:0] a);
    return a[31:IO_BITS] == IO_BASE[31:IO_BITS];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_CPU;
      we_q    <= 1'b0;
      is_io_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      is_io_q <= is_io_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    is_io_d = is_io_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (ldr_req) begin
          owner_d = OWN_LDR;
          we_d    = 1'b1;
          addr_d  = ldr_addr;
          wdata_d = ldr_wdata;
          is_io_d = addr_is_io(ldr_addr);
          cnt_d   = '0;
          state_d = ACCESS;
        end else if (cpu_req) begin
          owner_d = OWN_CPU;
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          is_io_d = addr_is_io(cpu_addr);
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        // Only memory reads linger here; every other access type finishes in one cycle.
        if (!we_q && !is_io_q) begin
          if (cnt_q == LAST_CNT) begin
            if (owner_q == OWN_CPU) begin
              rdata_d = mem_rdata;
            end
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          if (!we_q && owner_q == OWN_CPU) begin
            rdata_d = {16'h0000, io_rdata};
          end
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes decode from registered state so they drop to 0 the cycle after reset.
  assign mem_we      = (state_q == ACCESS) && we_q && !is_io_q;
  assign led_ctrl    = (state_q == ACCESS) && we_q && is_io_q && (owner_q == OWN_CPU);
  assign switch_ctrl = (state_q == ACCESS) && !we_q && is_io_q;

  assign cpu_ack = (state_q == DONE) && (owner_q == OWN_CPU);
  assign ldr_ack = (state_q == DONE) && (owner_q == OWN_LDR);
  assign busy    = (state_q != IDLE);

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign io_wdata  = wdata_q[15:0];
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_mem_io_access_ctrl.sv
// Directed bench for mem_io_access_ctrl with MEM_RD_LAT=2; expected values are hand-derived
// from the cycle timing (req sampled in cycle 0, strobe in cycle 1, ack in cycle 2 or LAT+1).
`timescale 1ns/1ps
module tb_mem_io_access_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        ldr_req;
  logic [31:0] ldr_addr;
  logic [31:0] ldr_wdata;
  logic        ldr_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [15:0] io_rdata;
  logic [15:0] io_wdata;
  logic        led_ctrl;
  logic        switch_ctrl;
  logic        busy;

  int n_checks;
  int n_fails;

  mem_io_access_ctrl #(
    .MEM_RD_LAT(2),
    .IO_BASE   (32'hFFFFFC00),
    .IO_BITS   (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .ldr_req    (ldr_req),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_ack    (ldr_ack),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .io_rdata   (io_rdata),
    .io_wdata   (io_wdata),
    .led_ctrl   (led_ctrl),
    .switch_ctrl(switch_ctrl),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    ldr_req   = 1'b0;
    ldr_addr  = '0;
    ldr_wdata = '0;
    mem_rdata = '0;
    io_rdata  = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    chk("rst_ldr_ack", {31'b0, ldr_ack}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    $display("txn reset: busy=%0b cpu_rdata=%h", busy, cpu_rdata);

    // CPU store to memory
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    step();
    chk("st_c1_mem_we", {31'b0, mem_we}, 32'd1);
    chk("st_c1_mem_addr", mem_addr, 32'h10);
    chk("st_c1_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_c1_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    chk("st_c1_busy", {31'b0, busy}, 32'd1);
    step();
    chk("st_c2_mem_we", {31'b0, mem_we}, 32'd0);
    chk("st_c2_cpu_ack", {31'b0, cpu_ack}, 32'd1);
    cpu_req = 1'b0;
    step();
    chk("st_c3_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    chk("st_c3_busy", {31'b0, busy}, 32'd0);
    chk("st_c3_addr_hold", mem_addr, 32'h10);
    $display("txn cpu store addr=00000010 data=deadbeef");

    // CPU load from memory, latency 2
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    step();
    chk("ld_c1_mem_we", {31'b0, mem_we}, 32'd0);
    chk("ld_c1_mem_addr", mem_addr, 32'h10);
    chk("ld_c1_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    step();
    chk("ld_c2_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    step();
    chk("ld_c3_cpu_ack", {31'b0, cpu_ack}, 32'd1);
    chk("ld_c3_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    cpu_req = 1'b0; mem_rdata = 32'h0;
    step();
    chk("ld_c4_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    chk("ld_c4_rdata_hold", cpu_rdata, 32'hDEADBEEF);
    $display("txn cpu load addr=00000010 rdata=%h", cpu_rdata);

    // CPU store to IO (LED)
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hFFFFFC60; cpu_wdata = 32'h1234ABCD;
    step();
    chk("iow_c1_led", {31'b0, led_ctrl}, 32'd1);
    chk("iow_c1_io_wdata", {16'h0, io_wdata}, 32'h0000ABCD);
    chk("iow_c1_mem_we", {31'b0, mem_we}, 32'd0);
    step();
    chk("iow_c2_led", {31'b0, led_ctrl}, 32'd0);
    chk("iow_c2_cpu_ack", {31'b0, cpu_ack}, 32'd1);
    chk("iow_c2_rdata_kept", cpu_rdata, 32'hDEADBEEF);
    cpu_req = 1'b0;
    step();
    $display("txn cpu io store addr=fffffc60 io_wdata=%h", io_wdata);

    // CPU load from IO (switches)
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hFFFFFC70; io_rdata = 16'h00F5;
    step();
    chk("ior_c1_switch", {31'b0, switch_ctrl}, 32'd1);
    chk("ior_c1_mem_we", {31'b0, mem_we}, 32'd0);
    step();
    chk("ior_c2_switch", {31'b0, switch_ctrl}, 32'd0);
    chk("ior_c2_cpu_ack", {31'b0, cpu_ack}, 32'd1);
    chk("ior_c2_cpu_rdata", cpu_rdata, 32'h000000F5);
    cpu_req = 1'b0; io_rdata = 16'h0;
    step();
    $display("txn cpu io load addr=fffffc70 rdata=%h", cpu_rdata);

    // Simultaneous requests: loader first, then CPU
    ldr_req = 1'b1; ldr_addr = 32'h20; ldr_wdata = 32'h000055AA;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h24; cpu_wdata = 32'h00000077;
    step();
    chk("arb_c1_mem_we", {31'b0, mem_we}, 32'd1);
    chk("arb_c1_mem_addr", mem_addr, 32'h20);
    chk("arb_c1_mem_wdata", mem_wdata, 32'h000055AA);
    step();
    chk("arb_c2_ldr_ack", {31'b0, ldr_ack}, 32'd1);
    chk("arb_c2_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    ldr_req = 1'b0;
    step();
    chk("arb_c3_ldr_ack", {31'b0, ldr_ack}, 32'd0);
    chk("arb_c3_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    step();
    chk("arb_c4_mem_we", {31'b0, mem_we}, 32'd1);
    chk("arb_c4_mem_addr", mem_addr, 32'h24);
    step();
    chk("arb_c5_cpu_ack", {31'b0, cpu_ack}, 32'd1);
    chk("arb_c5_ldr_ack", {31'b0, ldr_ack}, 32'd0);
    cpu_req = 1'b0;
    step();
    $display("txn arbitration loader then cpu");

    // Loader write to IO: no strobe, still acked
    ldr_req = 1'b1; ldr_addr = 32'hFFFFFC00; ldr_wdata = 32'h0000BEEF;
    step();
    chk("ldio_c1_led", {31'b0, led_ctrl}, 32'd0);
    chk("ldio_c1_mem_we", {31'b0, mem_we}, 32'd0);
    chk("ldio_c1_busy", {31'b0, busy}, 32'd1);
    step();
    chk("ldio_c2_ldr_ack", {31'b0, ldr_ack}, 32'd1);
    ldr_req = 1'b0;
    step();
    $display("txn loader io write addr=fffffc00 dropped");

    // Reset during a memory read, then restart with req still high
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; mem_rdata = 32'hCAFE0000;
    step();
    chk("abt_c1_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    step();
    chk("abt_busy", {31'b0, busy}, 32'd0);
    chk("abt_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    chk("abt_strobes", {29'b0, mem_we, led_ctrl, switch_ctrl}, 32'd0);
    chk("abt_cpu_rdata", cpu_rdata, 32'd0);
    rst = 1'b0;
    step();
    chk("rs_c1_busy", {31'b0, busy}, 32'd1);
    chk("rs_c1_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    chk("rs_c1_mem_addr", mem_addr, 32'h40);
    step();
    chk("rs_c2_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    step();
    chk("rs_c3_cpu_ack", {31'b0, cpu_ack}, 32'd1);
    chk("rs_c3_cpu_rdata", cpu_rdata, 32'hCAFE0000);
    cpu_req = 1'b0;
    step();
    chk("rs_c4_busy", {31'b0, busy}, 32'd0);
    $display("txn reset abort and restart rdata=%h", cpu_rdata);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
